// File: rtl/dvfs_pkg.sv
// Shared DVFS definitions: P-state/voltage widths, voltage table and sequencer state encoding.
// The DVFS utility block imports this too, so both sides agree on one voltage table.
package dvfs_pkg;

  localparam int PSTATE_W   = 2;
  localparam int VCODE_W    = 3;
  localparam int DIV_W      = 2;
  localparam int STATE_W    = 4;
  localparam int VBLANK_CYC = 2;

  typedef logic [PSTATE_W-1:0] pstate_t;
  typedef logic [VCODE_W-1:0]  vcode_t;

  localparam pstate_t P0        = '0;
  localparam vcode_t  VCODE_MAX = 3'd7;

  localparam logic [STATE_W-1:0] ST_IDLE    = 4'd0;
  localparam logic [STATE_W-1:0] ST_VSET    = 4'd1;
  localparam logic [STATE_W-1:0] ST_VBLANK  = 4'd2;
  localparam logic [STATE_W-1:0] ST_VWAIT   = 4'd3;
  localparam logic [STATE_W-1:0] ST_VSETTLE = 4'd4;
  localparam logic [STATE_W-1:0] ST_FSET    = 4'd5;
  localparam logic [STATE_W-1:0] ST_FSETTLE = 4'd6;
  localparam logic [STATE_W-1:0] ST_DONE    = 4'd7;
  localparam logic [STATE_W-1:0] ST_ERR     = 4'd8;

  // P0->7, P1->5, P2->3, P3->1
  function automatic vcode_t pstate_to_vcode(input pstate_t p);
    return VCODE_MAX - vcode_t'({p, 1'b0});
  endfunction

endpackage

// File: rtl/dvfs_settle_timer.sv
// Loadable down-counter with terminal-count flag; shared by the blanking, pgood-timeout
// and settle intervals of the P-state sequencer.
module dvfs_settle_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             cnt <= '0;
    else if (load)          cnt <= load_val;
    else if (cnt != '0)     cnt <= cnt - 1'b1;
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/dvfs_pstate_sequencer.sv
// Accepts a target P-state and steps regulator voltage and clock divider in a safe order:
// voltage before frequency when speeding up, frequency before voltage when slowing down.
module dvfs_pstate_sequencer
  import dvfs_pkg::*;
#(
  parameter int VSETTLE_CYC = 64,
  parameter int FSETTLE_CYC = 16,
  parameter int PGOOD_TMO   = 255,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_pstate,
  input  logic       req_valid,
  output logic       req_ready,
  output logic [2:0] vreg_code,
  output logic       vreg_set,
  input  logic       vreg_pgood,
  output logic [1:0] clk_div_sel,
  output logic [1:0] cur_pstate,
  output logic       busy,
  output logic       done,
  output logic       err
);

  logic [STATE_W-1:0] state, state_nxt;
  pstate_t            tgt, old, tgt_nxt;
  logic               accept, raise;
  logic               tmr_load, tmr_tc;
  logic [CNT_W-1:0]   tmr_val;

  assign accept  = req_valid && req_ready;
  assign tgt_nxt = accept ? req_pstate : tgt;
  assign raise   = (tgt < old);

  dvfs_settle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  // Each interval is loaded with N-1 on entry so the state lasts exactly N cycles.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_pstate == cur_pstate)     state_nxt = ST_DONE;
          else if (req_pstate < cur_pstate) state_nxt = ST_VSET;
          else                              state_nxt = ST_FSET;
        end
      end
      ST_VSET: begin
        state_nxt = ST_VBLANK;
        tmr_load  = 1'b1;
        tmr_val   = CNT_W'(VBLANK_CYC - 1);
      end
      ST_VBLANK: begin
        if (tmr_tc) begin
          state_nxt = ST_VWAIT;
          tmr_load  = 1'b1;
          tmr_val   = CNT_W'(PGOOD_TMO - 1);
        end
      end
      ST_VWAIT: begin
        if (vreg_pgood) begin
          state_nxt = ST_VSETTLE;
          tmr_load  = 1'b1;
          tmr_val   = CNT_W'(VSETTLE_CYC - 1);
        end else if (tmr_tc) begin
          state_nxt = ST_ERR;
        end
      end
      ST_VSETTLE: begin
        if (tmr_tc) state_nxt = raise ? ST_FSET : ST_DONE;
      end
      ST_FSET: begin
        state_nxt = ST_FSETTLE;
        tmr_load  = 1'b1;
        tmr_val   = CNT_W'(FSETTLE_CYC - 1);
      end
      ST_FSETTLE: begin
        if (tmr_tc) state_nxt = raise ? ST_DONE : ST_VSET;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs change on state entry so every output stays a plain register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      tgt         <= P0;
      old         <= P0;
      cur_pstate  <= P0;
      clk_div_sel <= '0;
      vreg_code   <= VCODE_MAX;
      vreg_set    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      req_ready   <= 1'b1;
    end else begin
      state     <= state_nxt;
      vreg_set  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      busy      <= (state_nxt != ST_IDLE);
      req_ready <= (state_nxt == ST_IDLE);
      if (accept) begin
        tgt <= req_pstate;
        old <= cur_pstate;
      end
      if (state_nxt != state) begin
        case (state_nxt)
          ST_VSET: begin
            vreg_code <= pstate_to_vcode(tgt_nxt);
            vreg_set  <= 1'b1;
          end
          ST_FSET: clk_div_sel <= tgt_nxt;
          ST_DONE: begin
            cur_pstate <= tgt_nxt;
            done       <= 1'b1;
          end
          // Restore the old voltage; the divider stays where it is, which is always safe.
          ST_ERR: begin
            vreg_code  <= pstate_to_vcode(old);
            vreg_set   <= 1'b1;
            err        <= 1'b1;
            cur_pstate <= clk_div_sel;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dvfs_pstate_sequencer.sv
// Scoreboard bench for dvfs_pstate_sequencer: a timeline model predicts each request's
// completion cycle and final outputs; a monitor pops and compares on every done/err pulse.
module tb_dvfs_pstate_sequencer;

  localparam int VSETTLE = 64;
  localparam int FSETTLE = 16;
  localparam int TMO     = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req_pstate = 2'd0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] vreg_code;
  logic       vreg_set;
  logic       vreg_pgood = 1'b1;
  logic [1:0] clk_div_sel;
  logic [1:0] cur_pstate;
  logic       busy, done, err;

  always #5 clk = ~clk;

  dvfs_pstate_sequencer #(
    .VSETTLE_CYC (VSETTLE),
    .FSETTLE_CYC (FSETTLE),
    .PGOOD_TMO   (TMO),
    .CNT_W       (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_pstate  (req_pstate),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .vreg_code   (vreg_code),
    .vreg_set    (vreg_set),
    .vreg_pgood  (vreg_pgood),
    .clk_div_sel (clk_div_sel),
    .cur_pstate  (cur_pstate),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  typedef struct {
    int is_err;
    int end_cyc;
    int cur;
    int div;
    int vcode;
    int vsets;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   vtab[4] = '{7, 5, 3, 1};
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   free_cyc = 0;
  int   m_cur = 0;
  int   m_div = 0;
  int   reg_d = 0;
  int   reg_rem = 0;
  int   vset_cnt = 0;
  int   dtab[10] = '{0, 0, 1, 3, 7, 20, 255, 257, 258, 300};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cur_pstate"}, cur_pstate, 0);
    chk({tag, "_clk_div_sel"}, clk_div_sel, 0);
    chk({tag, "_vreg_code"}, vreg_code, 7);
    chk({tag, "_vreg_set"}, vreg_set, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_req_ready"}, req_ready, 1);
  endtask

  // Regulator: after each vreg_set, pgood drops for d cycles (d=0 keeps it high).
  always @(negedge clk) begin
    if (vreg_set) begin
      reg_rem    = reg_d;
      vreg_pgood = (reg_d == 0);
    end else if (reg_rem > 0) begin
      reg_rem--;
      if (reg_rem == 0) vreg_pgood = 1'b1;
    end
  end

  // Monitor: every completion pulse is matched against the oldest prediction.
  always @(negedge clk) begin
    if (!rst_n) begin
      vset_cnt = 0;
      sbq.delete();
    end else begin
      if (vreg_set) vset_cnt++;
      chk("vcode_covers_div", int'(vreg_code >= vtab[clk_div_sel]), 1);
      if (done || err) begin
        if (sbq.size() == 0) begin
          chk("unexpected_completion", 1, 0);
        end else begin
          mon_e = sbq.pop_front();
          chk("err_vs_done", err, mon_e.is_err);
          chk("done_xor_err", done, 1 - mon_e.is_err);
          chk("completion_cycle", cyc, mon_e.end_cyc);
          chk("cur_pstate", cur_pstate, mon_e.cur);
          chk("clk_div_sel", clk_div_sel, mon_e.div);
          chk("vreg_code", vreg_code, mon_e.vcode);
          chk("vreg_set_count", vset_cnt, mon_e.vsets);
        end
        vset_cnt = 0;
      end
    end
  end

  // Presents a request (holding it while the sequencer is busy) and predicts its outcome.
  task automatic issue(input int tgt, input int d);
    exp_t e;
    int   old, s, c, rel;
    bit   ok;
    req_pstate = 2'(tgt);
    req_valid  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      chk("req_ready", req_ready, int'(cyc >= free_cyc));
      chk("busy", busy, int'(cyc < free_cyc));
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      return;
    end
    reg_d = d;
    old   = m_cur;
    if (tgt == old) begin
      rel = 1;
      e = '{is_err: 0, end_cyc: 0, cur: tgt, div: tgt, vcode: vtab[tgt], vsets: 0};
    end else begin
      s = (tgt < old) ? 1 : 1 + FSETTLE + 1;
      c = (d > 3) ? s + d : s + 3;
      if (c > s + 3 + TMO - 1) begin
        rel = s + 3 + TMO;
        e.is_err = 1;
        e.div    = (tgt < old) ? old : tgt;
        e.cur    = e.div;
        e.vcode  = vtab[old];
        e.vsets  = 2;
      end else begin
        rel = (tgt < old) ? c + VSETTLE + 1 + FSETTLE + 1 : c + VSETTLE + 1;
        e = '{is_err: 0, end_cyc: 0, cur: tgt, div: tgt, vcode: vtab[tgt], vsets: 1};
      end
    end
    e.end_cyc = cyc + rel;
    sbq.push_back(e);
    m_cur    = e.cur;
    m_div    = e.div;
    free_cyc = e.end_cyc + 1;
    @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset("post_reset");
    free_cyc = cyc;

    // Reset in the middle of a P0->P3 settle must drop straight to reset values.
    issue(3, 0);
    req_valid = 1'b0;
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset("mid_seq_reset");
    m_cur = 0;
    m_div = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset("after_mid_reset");
    free_cyc = cyc;

    issue(3, 0);
    issue(0, 7);
    issue(2, 0);
    issue(2, 0);
    issue(3, 0);
    issue(1, 300);
    issue(1, 257);
    issue(3, 258);
    issue(0, 0);

    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      issue(int'($urandom_range(0, 3)), dtab[$urandom_range(0, 9)]);
    end

    req_valid = 1'b0;
    for (int i = 0; i < 400 && cyc < free_cyc + 2; i++) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    chk("final_cur_pstate", cur_pstate, m_cur);
    chk("final_clk_div_sel", clk_div_sel, m_div);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
